pov_spi_tx: RTL and testbench
=============================

# pov_spi_tx

SPI master transmitter for point-of-view (POV) vector frames. It latches six signed fixed-point vectors on request and shifts them out MSB-first as one 144-bit frame on SCLK, /SS and MOSI. It is the transmitting end of the POV SPI link. It sits in the host-side or test-harness logic and drives the POV receiver in the raybox core, either over pins or as an on-chip loopback.

## Interface
Parameters:
- `FIELD_BITS`, default 24: width of each vector field. Frame length is 6×FIELD_BITS, 144 by default.
- `HALF_PERIOD`, default 4: clk cycles per SCLK half-period. Must be ≥4 so the receiver's 3-stage synchroniser resolves every level.
- `SS_LEAD`, default 4: clk cycles /SS is low before the first SCLK rise. Must be ≥3.
- `SS_TRAIL`, default 4: clk cycles /SS stays low after the last SCLK fall. Must be ≥3.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to send one frame; sampled only in IDLE.
- `playerX, playerY, facingX, facingY, vplaneX, vplaneY`  in  FIELD_BITS each  vector fields; latched on start acceptance.
- `busy`  out  1  high while a frame is in flight.
- `done`  out  1  one-cycle pulse when a frame completes.
- `o_sclk`  out  1  SPI clock, idle low (mode 0).
- `o_ss_n`  out  1  active-low slave select.
- `o_mosi`  out  1  serial data.

## Operation
- All outputs are registered.
- Reset values: `o_ss_n`=1, `o_sclk`=0, `o_mosi`=0, `busy`=0, `done`=0. The FSM goes to IDLE and the bit counter clears.
- The shift register loads {playerX, playerY, facingX, facingY, vplaneX, vplaneY}. Bit 143 is playerX[23] and is sent first.
- State IDLE:
  - If `start`=1, latch the frame, set `o_ss_n`=0 and `o_mosi`=frame[143], then go to LEAD.
  - Otherwise hold.
- State LEAD: `o_sclk`=0 for SS_LEAD cycles, then go to HIGH.
- State HIGH: `o_sclk`=1 for HALF_PERIOD cycles. The receiver samples on this rising edge.
  - If this was bit 144, go to TRAIL.
  - Otherwise go to LOW.
- State LOW: `o_sclk`=0. On entry, shift and drive the next bit on `o_mosi`. Hold for HALF_PERIOD cycles, then go to HIGH.
- State TRAIL: `o_sclk`=0 and `o_ss_n`=0 for SS_TRAIL cycles, then set `o_ss_n`=1 and go to GAP.
- State GAP: `o_ss_n`=1 for HALF_PERIOD cycles. This guarantees the receiver sees /SS inactive and resets its bit counter. Then go to IDLE and assert `done` for that first IDLE cycle.
- MOSI changes only while SCLK is low. It is stable for ≥HALF_PERIOD cycles before each rise.
- `start` while busy is ignored; there is no queuing.
- Input field changes after acceptance have no effect on the frame in flight.
- Reset mid-frame aborts the frame immediately. `o_ss_n` is 1 the cycle after, and no `done` pulse is issued.
- The 8-bit bit counter counts 0..143 and never wraps mid-frame.

## Timing
- `start` is sampled high at edge N. From N+1: `busy`=1 and `o_ss_n`=0.
- Busy duration = SS_LEAD + 288·HALF_PERIOD + SS_TRAIL cycles. With defaults this is 1160.
- First SCLK rise occurs at N+1+SS_LEAD.
- Rise k (k = 0..143) occurs at N+1+SS_LEAD+2k·HALF_PERIOD.
- `o_ss_n` returns high HALF_PERIOD cycles before `busy` falls.
- `done` is high in the single cycle where `busy` first reads 0.
- `start` may be re-accepted in that same cycle.

## Configuration
- Macro: `POV_SPI_TX_BACK_TO_BACK_EN`.
- Defined:
  - Condition: `start`=1 during the last TRAIL cycle.
  - Effect: GAP is skipped and `o_ss_n` stays 0.
  - New fields are latched and `o_mosi`=frame[143]. The FSM re-enters LEAD.
  - `done` pulses for one cycle while `busy` stays 1.
  - The receiver wraps its counter at 144 and accepts consecutive frames.
- Undefined: every frame ends with TRAIL+GAP and `start` is honoured only in IDLE.

## Test plan
- Reset: assert `reset` for 2 cycles, release. Expect `o_ss_n`=1, `o_sclk`=0, `o_mosi`=0, `busy`=0, `done`=0, held for 100 idle cycles.
- Single frame:
  - Stimulus: playerX=0x001800, playerY=0x001800, facingX=0, facingY=0x001000, vplaneX=0xFFF800, vplaneY=0; pulse `start`.
  - Bench SPI model sampling on SCLK rises captures exactly 144 bits equal to the concatenation.
  - `busy` is high for 1160 cycles and `done` pulses once.
- Start while busy: pulse `start` at bit 40. Expect no change to the frame, exactly one `done`, and busy length 1160.
- Reset mid-frame: assert `reset` at bit 70. Expect `o_ss_n`=1 next cycle and no `done`. The next frame is sent complete and correct.
- Loopback into the POV receiver: send frame A. Then pulse `load_if_ready`. Expect receiver playerX..vplaneY to equal frame A fields.
- With `POV_SPI_TX_BACK_TO_BACK_EN`: hold `start`=1 across two frames. Expect `o_ss_n` low continuously for 288 bits, two `done` pulses, and the receiver to load the second frame.

Source files
------------

// File: rtl/pov_spi_tx.sv
// rtl/pov_spi_tx.sv - SPI mode-0 master sending six POV vector fields as one frame
//
// Latches {playerX, playerY, facingX, facingY, vplaneX, vplaneY} on an accepted
// start and shifts the 6*FIELD_BITS frame out MSB-first on o_sclk/o_ss_n/o_mosi.
//
// Parameters:
//   FIELD_BITS   width of each vector field (frame = 6*FIELD_BITS bits)
//   HALF_PERIOD  clk cycles per SCLK half-period (>= 4)
//   SS_LEAD      clk cycles /SS is low before the first SCLK rise (>= 3)
//   SS_TRAIL     clk cycles /SS stays low after the last SCLK fall (>= 3)
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               frame request, sampled in IDLE
//   playerX..vplaneY    vector fields, latched on start acceptance
//   busy                high while a frame is in flight
//   done                one-cycle pulse when a frame completes
//   o_sclk, o_ss_n      SPI clock (idle low) and active-low slave select
//   o_mosi              serial data
//
// Optional feature macro: POV_SPI_TX_BACK_TO_BACK_EN
//   When defined, start during the last TRAIL cycle chains a new frame
//   directly (GAP skipped, /SS held low, done pulses while busy stays high).

module pov_spi_tx #(
    parameter int FIELD_BITS  = 24,
    parameter int HALF_PERIOD = 4,
    parameter int SS_LEAD     = 4,
    parameter int SS_TRAIL    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FIELD_BITS-1:0] playerX,
    input  logic [FIELD_BITS-1:0] playerY,
    input  logic [FIELD_BITS-1:0] facingX,
    input  logic [FIELD_BITS-1:0] facingY,
    input  logic [FIELD_BITS-1:0] vplaneX,
    input  logic [FIELD_BITS-1:0] vplaneY,
    output logic                  busy,
    output logic                  done,
    output logic                  o_sclk,
    output logic                  o_ss_n,
    output logic                  o_mosi
);

    localparam int FRAME_BITS = 6 * FIELD_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int TMR_W      = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TRAIL,
        S_GAP
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [TMR_W-1:0]        tmr;
    logic [TMR_W-1:0]        tmr_lim;
    logic                    tmr_last;
    logic [BIT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   frame;
    logic                    load;
    logic                    shift;

    assign frame = {playerX, playerY, facingX, facingY, vplaneX, vplaneY};

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        tmr_lim  = '0;

        case (state)
            S_LEAD:             tmr_lim = TMR_W'(SS_LEAD - 1);
            S_HIGH, S_LOW,
            S_GAP:              tmr_lim = TMR_W'(HALF_PERIOD - 1);
            S_TRAIL:            tmr_lim = TMR_W'(SS_TRAIL - 1);
            default:            tmr_lim = '0;
        endcase
        tmr_last = (tmr == tmr_lim);

        case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    state_nx = S_LEAD;
                end
            end
            S_LEAD: begin
                if (tmr_last) state_nx = S_HIGH;
            end
            S_HIGH: begin
                if (tmr_last) begin
                    if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                        state_nx = S_TRAIL;
                    end else begin
                        shift    = 1'b1;
                        state_nx = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (tmr_last) state_nx = S_HIGH;
            end
            S_TRAIL: begin
                if (tmr_last) begin
`ifdef POV_SPI_TX_BACK_TO_BACK_EN
                    if (start) begin
                        load     = 1'b1;
                        state_nx = S_LEAD;
                    end else begin
                        state_nx = S_GAP;
                    end
`else
                    state_nx = S_GAP;
`endif
                end
            end
            S_GAP: begin
                if (tmr_last) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each pin changes on the
    // same edge as the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            o_sclk  <= 1'b0;
            o_ss_n  <= 1'b1;
            o_mosi  <= 1'b0;
        end else begin
            state <= state_nx;

            if (state_nx != state || state == S_IDLE) begin
                tmr <= '0;
            end else begin
                tmr <= tmr + TMR_W'(1);
            end

            if (load) begin
                shreg   <= frame;
                bit_cnt <= '0;
                o_mosi  <= frame[FRAME_BITS-1];
            end else if (shift) begin
                // Next bit goes out on entry to LOW, a full half-period before the rise.
                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_W'(1);
                o_mosi  <= shreg[FRAME_BITS-2];
            end

            o_sclk <= (state_nx == S_HIGH);
            o_ss_n <= !(state_nx inside {S_LEAD, S_HIGH, S_LOW, S_TRAIL});
            busy   <= (state_nx != S_IDLE);
            done   <= (state == S_GAP && state_nx == S_IDLE) ||
                      (state == S_TRAIL && load);
        end
    end

endmodule

// File: tb/tb_pov_spi_tx.sv
// tb/tb_pov_spi_tx.sv - self-checking bench for pov_spi_tx
module tb_pov_spi_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
    logic        busy, done, o_sclk, o_ss_n, o_mosi;

    int total = 0;
    int bad   = 0;

    pov_spi_tx dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .playerX (playerX),
        .playerY (playerY),
        .facingX (facingX),
        .facingY (facingY),
        .vplaneX (vplaneX),
        .vplaneY (vplaneY),
        .busy    (busy),
        .done    (done),
        .o_sclk  (o_sclk),
        .o_ss_n  (o_ss_n),
        .o_mosi  (o_mosi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0][23:0] f;          // f[5]=playerX ... f[0]=vplaneY
        logic [143:0]     exp_frame;
    } vec_t;

    vec_t vecs[5];

    // SPI receiver model: captures MOSI on every SCLK rise.
    logic [143:0] rx;
    int           rises, dones, blen, first_off, glitch, ss_hi;
    logic         p_sclk = 1'b0;
    logic         p_mosi = 1'b0;

    always @(negedge clk) begin
        if (o_sclk && !p_sclk) begin
            if (rises == 0) first_off = blen;
            rx = {rx[142:0], o_mosi};
            rises++;
            if (o_mosi !== p_mosi) glitch++;
        end
        if (o_sclk && p_sclk && o_mosi !== p_mosi) glitch++;
        if (!busy && !o_ss_n) glitch++;
        if (done) dones++;
        if (busy) blen++;
        if (busy && o_ss_n) ss_hi++;
        p_sclk = o_sclk;
        p_mosi = o_mosi;
    end

    task automatic mon_clr();
        rx = '0; rises = 0; dones = 0; blen = 0; first_off = -1; glitch = 0; ss_hi = 0;
    endtask

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_fields(input logic [5:0][23:0] f);
        playerX = f[5]; playerY = f[4]; facingX = f[3];
        facingY = f[2]; vplaneX = f[1]; vplaneY = f[0];
    endtask

    task automatic kick(input logic [5:0][23:0] f);
        @(posedge clk); #1;
        set_fields(f);
        start = 1'b1;
        mon_clr();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < 6000 && rises < n; i++) @(negedge clk);
        total++;
        if (rises < n) begin
            bad++;
            $display("FAIL timeout_rises: got %0d want %0d", rises, n);
        end
    endtask

    task automatic wait_dones(input int n);
        for (int i = 0; i < 6000 && dones < n; i++) @(negedge clk);
        total++;
        if (dones < n) begin
            bad++;
            $display("FAIL timeout_done: got %0d want %0d", dones, n);
        end
    endtask

    initial begin
        vecs[0].f = {24'h001800, 24'h001800, 24'h000000, 24'h001000, 24'hFFF800, 24'h000000};
        vecs[0].exp_frame = 144'h001800_001800_000000_001000_FFF800_000000;
        vecs[1].f = {24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
        vecs[1].exp_frame = 144'h000000_000000_000000_000000_000000_000000;
        vecs[2].f = {24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[2].exp_frame = 144'hFFFFFF_FFFFFF_FFFFFF_FFFFFF_FFFFFF_FFFFFF;
        vecs[3].f = {24'h800000, 24'h000001, 24'hAAAAAA, 24'h555555, 24'h123456, 24'hFEDCBA};
        vecs[3].exp_frame = 144'h800000_000001_AAAAAA_555555_123456_FEDCBA;
        vecs[4].f = {24'h7FFFFF, 24'h800000, 24'h000000, 24'hFFFFFF, 24'h0F0F0F, 24'hF0F0F0};
        vecs[4].exp_frame = 144'h7FFFFF_800000_000000_FFFFFF_0F0F0F_F0F0F0;

        reset = 1'b1;
        start = 1'b0;
        set_fields(vecs[1].f);
        mon_clr();

        // Reset state, then held through 100 idle cycles.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ss_n", 144'(o_ss_n), 144'd1);
        chk("rst_sclk", 144'(o_sclk), 144'd0);
        chk("rst_mosi", 144'(o_mosi), 144'd0);
        chk("rst_busy", 144'(busy),   144'd0);
        chk("rst_done", 144'(done),   144'd0);
        begin
            int viol = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (o_ss_n !== 1'b1 || o_sclk !== 1'b0 || o_mosi !== 1'b0 ||
                    busy !== 1'b0 || done !== 1'b0) viol++;
            end
            chk("rst_hold_viol", 144'(viol), 144'd0);
        end

        // Table-driven single frames.
        for (int v = 0; v < 5; v++) begin
            kick(vecs[v].f);
            wait_dones(1);
            repeat (6) @(negedge clk);
            chk($sformatf("v%0d_frame", v), rx, vecs[v].exp_frame);
            chk($sformatf("v%0d_rises", v), 144'(rises), 144'd144);
            chk($sformatf("v%0d_busy_len", v), 144'(blen), 144'd1160);
            chk($sformatf("v%0d_done_cnt", v), 144'(dones), 144'd1);
            chk($sformatf("v%0d_first_rise", v), 144'(first_off), 144'd4);
            chk($sformatf("v%0d_mosi_ss_rules", v), 144'(glitch), 144'd0);
            chk($sformatf("v%0d_ss_gap", v), 144'(ss_hi), 144'd4);
            if (v == 3) begin
                // Loopback: receiver-side field split of frame A.
                chk("lb_playerX", 144'(rx[143:120]), 144'(vecs[3].f[5]));
                chk("lb_playerY", 144'(rx[119:96]),  144'(vecs[3].f[4]));
                chk("lb_facingX", 144'(rx[95:72]),   144'(vecs[3].f[3]));
                chk("lb_facingY", 144'(rx[71:48]),   144'(vecs[3].f[2]));
                chk("lb_vplaneX", 144'(rx[47:24]),   144'(vecs[3].f[1]));
                chk("lb_vplaneY", 144'(rx[23:0]),    144'(vecs[3].f[0]));
            end
        end

        // Start while busy at bit 40, with fields changed: frame unaffected.
        kick(vecs[0].f);
        wait_rises(40);
        #1;
        set_fields(vecs[3].f);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_dones(1);
        repeat (20) @(negedge clk);
        chk("sb_frame", rx, vecs[0].exp_frame);
        chk("sb_done_cnt", 144'(dones), 144'd1);
        chk("sb_busy_len", 144'(blen), 144'd1160);

        // Reset mid-frame at bit 70.
        kick(vecs[2].f);
        wait_rises(70);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("mr_ss_n", 144'(o_ss_n), 144'd1);
        chk("mr_busy", 144'(busy), 144'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("mr_no_done", 144'(dones), 144'd0);
        kick(vecs[4].f);
        wait_dones(1);
        repeat (6) @(negedge clk);
        chk("mr_next_frame", rx, vecs[4].exp_frame);
        chk("mr_next_busy_len", 144'(blen), 144'd1160);

`ifdef POV_SPI_TX_BACK_TO_BACK_EN
        // Two chained frames with start held; second frame carries new fields.
        @(posedge clk); #1;
        set_fields(vecs[0].f);
        start = 1'b1;
        mon_clr();
        wait_rises(100);
        set_fields(vecs[3].f);
        wait_dones(1);
        start = 1'b0;
        wait_dones(2);
        repeat (6) @(negedge clk);
        chk("b2b_done_cnt", 144'(dones), 144'd2);
        chk("b2b_rises", 144'(rises), 144'd288);
        chk("b2b_frame2", rx, vecs[3].exp_frame);
        chk("b2b_ss_hi", 144'(ss_hi), 144'd4);
        chk("b2b_busy_len", 144'(blen), 144'd2316);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
